// File: rtl/hash_word_reader.sv
// hash_word_reader
//   Snapshots the eight 32-bit working variables A..H when start is seen in
//   IDLE, then streams them out over a valid/ready handshake. The stream is
//   either one beat per word or one beat per byte. In byte mode the most
//   significant byte of each word comes first and sits in out_data[7:0].
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      snapshot request (honoured in IDLE only)
//   byte_mode  sampled with start: 0 = word stream, 1 = byte stream
//   in_A..in_H working variables to be read out
//   out_data   beat payload (word, or zero-extended byte)
//   out_addr   word address of the beat, 1 = A ... 8 = H
//   out_valid  beat valid
//   out_ready  sink accepts beat
//   busy       high while streaming
//   done       one-cycle pulse after the final beat is accepted
module hash_word_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_mode,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [31:0] in_C,
    input  logic [31:0] in_D,
    input  logic [31:0] in_E,
    input  logic [31:0] in_F,
    input  logic [31:0] in_G,
    input  logic [31:0] in_H,
    output logic [31:0] out_data,
    output logic [3:0]  out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] word_buf [8];
    logic [2:0]  word_idx;
    logic [1:0]  byte_idx;
    logic        mode_q;

    logic        sending;
    logic        last_beat;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;

    assign sending  = (state == ST_SEND);
    assign cur_word = word_buf[word_idx];

    // Final beat is word H, or byte 3 of word H in byte mode.
    assign last_beat = (word_idx == 3'd7) && (!mode_q || (byte_idx == 2'd3));

    // Byte index 0 selects the most significant byte.
    always_comb begin
        cur_byte = cur_word[31:24];
        case (byte_idx)
            2'd0: cur_byte = cur_word[31:24];
            2'd1: cur_byte = cur_word[23:16];
            2'd2: cur_byte = cur_word[15:8];
            2'd3: cur_byte = cur_word[7:0];
            default: cur_byte = cur_word[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_idx <= 3'd0;
            byte_idx <= 2'd0;
            mode_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                word_buf[i] <= 32'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_buf[0] <= in_A;
                        word_buf[1] <= in_B;
                        word_buf[2] <= in_C;
                        word_buf[3] <= in_D;
                        word_buf[4] <= in_E;
                        word_buf[5] <= in_F;
                        word_buf[6] <= in_G;
                        word_buf[7] <= in_H;
                        mode_q      <= byte_mode;
                        word_idx    <= 3'd0;
                        byte_idx    <= 2'd0;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (mode_q) begin
                            byte_idx <= byte_idx + 2'd1;
                            // Word advances only when the byte index wraps.
                            if (byte_idx == 2'd3) begin
                                word_idx <= word_idx + 3'd1;
                            end
                        end else begin
                            word_idx <= word_idx + 3'd1;
                        end
                        if (last_beat) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced to zero outside SEND so reset clears them at once.
    assign out_valid = sending;
    assign busy      = sending;
    assign done      = (state == ST_DONE);
    assign out_data  = !sending ? 32'd0 : (mode_q ? {24'd0, cur_byte} : cur_word);
    assign out_addr  = sending ? ({1'b0, word_idx} + 4'd1) : 4'd0;

endmodule

// File: tb/tb_hash_word_reader.sv
module tb_hash_word_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_mode;
    logic [31:0] in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] w [8];

    hash_word_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .byte_mode (byte_mode),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_C      (in_C),
        .in_D      (in_D),
        .in_E      (in_E),
        .in_F      (in_F),
        .in_G      (in_G),
        .in_H      (in_H),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_words();
        in_A = w[0]; in_B = w[1]; in_C = w[2]; in_D = w[3];
        in_E = w[4]; in_F = w[5]; in_G = w[6]; in_H = w[7];
    endtask

    task automatic scramble_inputs();
        in_A = $urandom; in_B = $urandom; in_C = $urandom; in_D = $urandom;
        in_E = $urandom; in_F = $urandom; in_G = $urandom; in_H = $urandom;
        byte_mode = 1'($urandom);
    endtask

    // rmode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random ready
    task automatic run_stream(input bit mode, input int rmode, input bit disturb);
        logic [35:0] exp_q [$];
        logic [35:0] head;
        int          cyc;
        bit          finished;
        bit          rdy;

        // Reference: list of beats the sink must see, in order.
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (!mode) begin
                exp_q.push_back({4'(i + 1), w[i]});
            end else begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back({4'(i + 1), (w[i] >> (24 - 8 * b)) & 32'hff});
                end
            end
        end

        @(negedge clk);
        drive_words();
        byte_mode = mode;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (disturb) scramble_inputs();

        cyc      = 0;
        finished = 1'b0;
        while (!finished && cyc < 400) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            @(negedge clk);
            check("valid_in_send", {31'd0, out_valid}, 32'd1);
            check("busy_in_send", {31'd0, busy}, 32'd1);
            check("no_done_in_send", {31'd0, done}, 32'd0);
            head = exp_q[0];
            check("beat_addr", {28'd0, out_addr}, {28'd0, head[35:32]});
            check("beat_data", out_data, head[31:0]);
            if (out_valid && rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
                if (disturb) begin
                    scramble_inputs();
                    start = ($urandom_range(0, 3) == 0);
                end
            end
            cyc++;
        end
        if (!finished) check("stream_timeout", 32'd0, 32'd1);

        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'($urandom);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("valid_in_done", {31'd0, out_valid}, 32'd0);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("valid_after_done", {31'd0, out_valid}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic sha_init();
        w[0] = 32'h6a09e667; w[1] = 32'hbb67ae85; w[2] = 32'h3c6ef372; w[3] = 32'ha54ff53a;
        w[4] = 32'h510e527f; w[5] = 32'h9b05688c; w[6] = 32'h1f83d9ab; w[7] = 32'h5be0cd19;
    endtask

    task automatic random_words();
        for (int i = 0; i < 8; i++) w[i] = $urandom;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        byte_mode = 1'b0;
        out_ready = 1'b0;
        sha_init();
        drive_words();

        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", {28'd0, out_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Word stream of the SHA-256 initial values, full throughput.
        sha_init();
        run_stream(1'b0, 0, 1'b0);
        // Byte stream, full throughput.
        run_stream(1'b1, 0, 1'b0);
        // Backpressure pattern.
        run_stream(1'b0, 1, 1'b0);
        run_stream(1'b1, 1, 1'b0);
        // Inputs and start disturbed after the snapshot.
        run_stream(1'b0, 0, 1'b1);

        // Randomized streams.
        for (int k = 0; k < 6; k++) begin
            random_words();
            run_stream(1'(k), 2, 1'b1);
        end

        // Reset mid-stream after beat 3.
        sha_init();
        @(negedge clk);
        drive_words();
        byte_mode = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_addr", {28'd0, out_addr}, 32'd4);
        check("abort_pre_data", out_data, w[3]);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {28'd0, out_addr}, 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_idle_done", {31'd0, done}, 32'd0);
            check("abort_idle_valid", {31'd0, out_valid}, 32'd0);
        end
        random_words();
        run_stream(1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hash_word_reader.md
HASH_WORD_READER -- requirements
Module: hash_word_reader

Interface
REQ-001 Parameter: none; word count fixed at 8, word width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to snapshot and stream the eight working words.
REQ-005 byte_mode  input  1  sampled with start; 0 = word stream, 1 = byte stream.
REQ-006 in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H  input  32 each  working variables A..H to be read out.
REQ-007 out_data  output  32  current beat payload.
REQ-008 out_addr  output  4  address of the word the current beat belongs to, 1 = A ... 8 = H (same addressing as the write-side controller).
REQ-009 out_valid  output  1  beat on out_data/out_addr is valid.
REQ-010 out_ready  input  1  sink accepts beat.
REQ-011 busy  output  1  high in SEND state.
REQ-012 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-013 FSM states: IDLE, SEND, DONE; encoding is free.
REQ-014 IDLE: out_valid=0, busy=0, done=0; start=1 at a posedge -> snapshot in_A..in_H into an internal 8x32 buffer, latch byte_mode, clear word index (3 bits) and byte index (2 bits), go to SEND.
REQ-015 Latency: first beat has out_valid=1 in the cycle immediately after the start cycle.
REQ-016 SEND: out_valid=1, busy=1; a beat transfers at a posedge where out_valid=1 and out_ready=1.
REQ-017 Word mode: out_data = buffer[word index], order A, B, ..., H; out_addr = word index + 1; 8 beats total.
REQ-018 Byte mode: out_data[31:8]=0, out_data[7:0] = byte of buffer[word index], most significant byte first; out_addr = word index + 1 for all 4 bytes of that word; 32 beats total.
REQ-019 On transfer: byte mode increments byte index, incrementing word index when byte index wraps 3->0; word mode increments word index.
REQ-020 out_data and out_addr shall stay stable while out_valid=1 and out_ready=0 (no beat dropped, none repeated).
REQ-021 Transfer of the last beat (word H, or byte 3 of H) -> DONE next cycle: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-022 start in SEND or DONE is ignored; no re-snapshot, no restart.
REQ-023 Changes on in_A..in_H or byte_mode after the snapshot shall not affect the stream in progress.
REQ-024 out_ready is ignored outside SEND; holding out_ready=1 continuously yields one beat per cycle with no bubbles.

Reset
REQ-025 rst_n=0 forces immediately, independent of clk: state IDLE, out_valid=0, busy=0, done=0, out_data=0, out_addr=0, indices=0, buffer=0.
REQ-026 Reset asserted mid-stream aborts it; no done pulse; after release the block waits in IDLE for a new start.
REQ-027 Deassertion of rst_n is expected synchronous to clk externally; the block itself does no synchronization.

Verification
REQ-028 Word mode, out_ready=1: in_A=6a09e667 ... in_H=5be0cd19, start one cycle -> beats 1..8 on consecutive cycles from the cycle after start, addr 1..8 with matching data, done high the cycle after addr 8.
REQ-029 Byte mode, out_ready=1: in_A=6a09e667, start -> first four beats 0x6a, 0x09, 0xe6, 0x67 with addr=1; 32 beats total, then done.
REQ-030 Backpressure: out_ready toggled 1,0,0,1,... -> every held beat unchanged while ready=0, sink receives exactly A..H in order once each.
REQ-031 Snapshot: change in_C to deadbeef two cycles after start -> stream still carries the start-cycle value of C at addr 3; start pulsed during SEND has no effect.
REQ-032 rst_n pulled low after beat 3 -> out_valid, busy, out_addr, out_data go 0 without a clock edge, no done; new start after release streams from addr 1.
